relu_maxpool_nch: RTL and testbench
===================================

Name: relu_maxpool_nch

Overview:
- N-channel post-convolution stage for the VGG16 datapath.
- Applies ReLU and 2x2 stride-2 max pooling to CHANNELS parallel IEEE-754 fp32 pixel streams in raster order.
- Produces a (WIDTH/2)x(HEIGHT/2) pooled map per channel on one packed bus, with frame tracking and a done pulse.
- Sits directly after any conv3d bank, replacing per-channel activate + max_pooling instances.

Parameters:
- DATA_WIDTH, 32, element width; fp32 only.
- CHANNELS, 8, parallel channels on the bus.
- WIDTH, 56, input columns; must be >= 2.
- HEIGHT, 56, input rows; must be >= 2.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- valid_in  in  1  one pixel per channel accepted this cycle.
- data_in  in  CHANNELS*DATA_WIDTH  channel c at bits [c*DATA_WIDTH +: DATA_WIDTH].
- data_out  out  CHANNELS*DATA_WIDTH  pooled pixels, same packing.
- valid_out  out  1  data_out valid, 1-cycle pulse per pooled pixel.
- done  out  1  1-cycle pulse at end of frame.
- busy  out  1  high while a frame is partially received.

Behaviour:
- Reset (async, resetn=0): data_out=0, valid_out=0, done=0, busy=0; col=row=0; FSM=IDLE. Line buffer contents are not reset and are don't-care.
- Reset mid-frame discards the partial frame. The next valid_in starts a new frame at (0,0).
- Counters: col 0..WIDTH-1 and row 0..HEIGHT-1 advance only on valid_in=1. col wraps to 0 and row increments at WIDTH-1. valid_in=0 stalls all state.
- FSM states:
  - IDLE: first valid_in goes to EVEN_ROW and sets busy.
  - EVEN_ROW (row even): on col wrap, go to ODD_ROW.
  - ODD_ROW: on col wrap, go to EVEN_ROW; go to SKIP_ROW if the next row is HEIGHT-1 and HEIGHT is odd; go to IDLE if this was the last row.
  - SKIP_ROW: pixels consumed and discarded; on col wrap, go to IDLE.
- EVEN_ROW datapath:
  - Even col: pixel stored in h_reg[c].
  - Odd col: max(h_reg[c], pix) written to linebuf[col>>1].
- ODD_ROW datapath:
  - Even col: h_reg[c] loaded.
  - Odd col: data_out[c] <= max(linebuf[col>>1], max(h_reg[c], pix)) and valid_out <= 1.
  - Latency: valid_out is asserted 1 cycle after the bottom-right pixel of each window is accepted.
- Odd WIDTH: column WIDTH-1 is ignored (floor semantics, Keras "valid" padding).
- ReLU: a pixel with sign bit = 1 maps to 32'h00000000. Applied on entry, before h_reg/linebuf.
- max(a,b), compared on bit patterns, sign-magnitude:
  - Differing signs: the sign=0 operand wins.
  - Both sign=0: larger unsigned [30:0] wins.
  - Both sign=1: smaller [30:0] wins.
  - Ties keep a.
  - NaN gets no special handling.
- done: pulses 1 cycle after the last pixel (WIDTH-1, HEIGHT-1) is accepted; busy falls in the same cycle.
  - Even HEIGHT: done coincides with the final valid_out.
  - Odd HEIGHT: done comes after the skipped row.
- Back-to-back frames: valid_in in the cycle done is high is accepted as pixel (0,0) of the next frame. No bubble is required.
- valid_out deasserts after 1 cycle. data_out holds its last value.

Optional Feature:
- Macro: RELU_EN.
- Defined: ReLU applied on entry as above.
- Undefined: raw max pooling of signed values; negative results propagate unchanged.
- Comparator and timing are identical in both builds.

Decomposition:
- Shared include vgg_pkg.vh holds:
  - FSM state localparams IDLE/EVEN_ROW/ODD_ROW/SKIP_ROW (2-bit).
  - FP32_ZERO and FP_SIGN_BIT constants.
- One natural sub-module, fp32_max2: combinational max(a,b) per the rules above. Three instances per channel inside a generate loop over CHANNELS.
- Line buffer: a single array of depth WIDTH/2 and width CHANNELS*DATA_WIDTH, shared by all channels.

Test Plan:
- CHANNELS=2, WIDTH=HEIGHT=4, RELU_EN defined; ch0 window values 3f800000, 40000000, 3f000000, c0400000 -> ch0 out 40000000, 1 cycle after pixel (1,1); 4 valid_out total; done with the 4th.
- Same config, all four ch1 window pixels c0400000 -> ch1 out 00000000. Rebuild without RELU_EN -> c0400000.
- WIDTH=5, HEIGHT=5, ramp input 0..24 as fp32 -> outputs 6,8,16,18 (fp32); column 4 and row 4 ignored; done 1 cycle after pixel 24; exactly 4 valid_out.
- valid_in toggling 1-0-1 every cycle over a 4x4 frame -> outputs identical to the contiguous run; each valid_out 1 cycle after the accepting edge.
- resetn pulsed low after 6 pixels -> all outputs 0 immediately. A full 4x4 frame afterward gives correct results with no stale window data.
- Two 4x4 frames back-to-back with no gap -> 8 valid_out, two done pulses, second frame correct.

Source files
------------

// File: rtl/relu_maxpool_nch_pkg.sv
// relu_maxpool_nch_pkg: shared FSM states and fp32 constants for the pooling stage
package relu_maxpool_nch_pkg;
  typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW, SKIP_ROW} state_t;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam int FP_SIGN_BIT = 31;
endpackage

// File: rtl/fp32_max2.sv
// fp32_max2: sign-magnitude max of two fp32 bit patterns; ties keep a, no NaN handling
module fp32_max2 import relu_maxpool_nch_pkg::*; (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic sa, sb, a_wins;
  assign sa = a[FP_SIGN_BIT];
  assign sb = b[FP_SIGN_BIT];
  assign a_wins = (sa != sb) ? !sa : sa ? (a[30:0] <= b[30:0]) : (a[30:0] >= b[30:0]);
  assign y = a_wins ? a : b;
endmodule

// File: rtl/relu_maxpool_nch.sv
// relu_maxpool_nch: N-channel 2x2 stride-2 fp32 max pooling over raster streams.
// Define RELU_EN to clamp negative inputs to +0 before pooling.
module relu_maxpool_nch import relu_maxpool_nch_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 8,
  parameter int WIDTH      = 56,
  parameter int HEIGHT     = 56
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           valid_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           valid_out,
  output logic                           done,
  output logic                           busy
);
  localparam int BW = CHANNELS * DATA_WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam int LD = WIDTH / 2;
  localparam int LW = (LD > 1) ? $clog2(LD) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic col_last, row_last, even_op, odd_op;
  logic [BW-1:0] pix, h_reg, pair, win, lb_rd;
  logic [BW-1:0] linebuf [LD];
  logic [LW-1:0] lb_idx;
  assign col_last = col == CW'(WIDTH - 1);
  assign row_last = row == RW'(HEIGHT - 1);
  assign lb_idx = LW'(col >> 1);
  assign lb_rd = linebuf[lb_idx];
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
`ifdef RELU_EN
    fp32_max2 u_relu (.a(data_in[c*DATA_WIDTH +: DATA_WIDTH]), .b(FP32_ZERO), .y(pix[c*DATA_WIDTH +: DATA_WIDTH]));
`else
    assign pix[c*DATA_WIDTH +: DATA_WIDTH] = data_in[c*DATA_WIDTH +: DATA_WIDTH];
`endif
    fp32_max2 u_h (.a(h_reg[c*DATA_WIDTH +: DATA_WIDTH]), .b(pix[c*DATA_WIDTH +: DATA_WIDTH]), .y(pair[c*DATA_WIDTH +: DATA_WIDTH]));
    fp32_max2 u_v (.a(lb_rd[c*DATA_WIDTH +: DATA_WIDTH]), .b(pair[c*DATA_WIDTH +: DATA_WIDTH]), .y(win[c*DATA_WIDTH +: DATA_WIDTH]));
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (valid_in)
      case (state)
        IDLE:     state_nxt = EVEN_ROW;
        EVEN_ROW: state_nxt = col_last ? ODD_ROW : EVEN_ROW;
        ODD_ROW:  state_nxt = !col_last ? ODD_ROW : row_last ? IDLE :
                              (HEIGHT % 2 == 1 && row == RW'(HEIGHT - 2)) ? SKIP_ROW : EVEN_ROW;
        default:  state_nxt = col_last ? IDLE : SKIP_ROW;
      endcase
  end
  always_comb begin
    busy = state != IDLE;
    even_op = valid_in && (state == IDLE || state == EVEN_ROW);
    odd_op = valid_in && state == ODD_ROW;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      col <= '0;
      row <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
      done <= 1'b0;
    end else begin
      valid_out <= odd_op && col[0];
      done <= valid_in && col_last && row_last;
      if (valid_in) col <= col_last ? '0 : col + 1'b1;
      if (valid_in && col_last) row <= row_last ? '0 : row + 1'b1;
      if (odd_op && col[0]) data_out <= win;
    end
  // window storage needs no reset: every slot is written before it is read in a frame
  always_ff @(posedge clk) begin
    if (valid_in && !col[0]) h_reg <= pix;
    if (even_op && col[0]) linebuf[lb_idx] <= pair;
  end
endmodule

// File: tb/tb_relu_maxpool_nch.sv
// tb_relu_maxpool_nch: directed checks of a 4x4 and a 5x5 two-channel pooling instance
module tb_relu_maxpool_nch;
  logic clk = 0, resetn = 0;
  logic vi4 = 0, vi5 = 0;
  logic [63:0] di4 = '0, di5 = '0;
  logic [63:0] do4, do5;
  logic vo4, vo5, done4, done5, busy4, busy5;
  logic [63:0] last4;
  int n_pass = 0, n_chk = 0;

  logic [31:0] f [2][16] = '{
    '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h3f800000,
      32'h3f000000, 32'hc0400000, 32'h40800000, 32'hc0800000,
      32'h41000000, 32'hc1000000, 32'h3f800000, 32'h3f800000,
      32'h40e00000, 32'h40a00000, 32'hbf800000, 32'hbf800000},
    '{32'hc0400000, 32'hc0400000, 32'hbf800000, 32'hc0000000,
      32'hc0400000, 32'hc0400000, 32'hc0400000, 32'h80000000,
      32'h3f800000, 32'h00000000, 32'hc0a00000, 32'hc0a00000,
      32'h00000000, 32'h3f800000, 32'hc0a00000, 32'hc0a00000}};
`ifdef RELU_EN
  logic [31:0] e [2][4] = '{'{32'h40000000, 32'h40800000, 32'h41000000, 32'h3f800000},
                            '{32'h00000000, 32'h00000000, 32'h3f800000, 32'h00000000}};
`else
  logic [31:0] e [2][4] = '{'{32'h40000000, 32'h40800000, 32'h41000000, 32'h3f800000},
                            '{32'hc0400000, 32'h80000000, 32'h3f800000, 32'hc0a00000}};
`endif
  logic [31:0] e5 [4] = '{32'h40c00000, 32'h41000000, 32'h41800000, 32'h41900000};

  relu_maxpool_nch #(.DATA_WIDTH(32), .CHANNELS(2), .WIDTH(4), .HEIGHT(4)) u_d4 (
    .clk(clk), .resetn(resetn), .valid_in(vi4), .data_in(di4),
    .data_out(do4), .valid_out(vo4), .done(done4), .busy(busy4));
  relu_maxpool_nch #(.DATA_WIDTH(32), .CHANNELS(2), .WIDTH(5), .HEIGHT(5)) u_d5 (
    .clk(clk), .resetn(resetn), .valid_in(vi5), .data_in(di5),
    .data_out(do5), .valid_out(vo5), .done(done5), .busy(busy5));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] itof(input int v);
    int ex = 0;
    if (v == 0) return 32'h0;
    for (int i = 0; i < 31; i++) if ((v >> i) != 0) ex = i;
    return {1'b0, 8'(127 + ex), 23'((v << (23 - ex)) & 32'h7fffff)};
  endfunction

  task automatic frame4(input bit sw, input bit gap, input int npix);
    int w = 0;
    for (int k = 0; k < npix; k++) begin
      vi4 = 1;
      di4 = {f[1^sw][k], f[0^sw][k]};
      @(posedge clk); #1;
      vi4 = 0;
      if ((k / 4) % 2 == 1 && (k % 4) % 2 == 1) begin
        last4 = {e[1^sw][w], e[0^sw][w]};
        chk("vo4", vo4, 1);
        chk("dout4", do4, last4);
        w++;
      end else chk("vo4_idle", vo4, 0);
      chk("done4", done4, k == 15);
      chk("busy4", busy4, k != 15);
      if (gap) begin
        @(posedge clk); #1;
        chk("vo4_gap", vo4, 0);
        chk("done4_gap", done4, 0);
        chk("hold4", do4, last4);
      end
    end
  endtask

  task automatic frame5();
    int w = 0;
    for (int k = 0; k < 25; k++) begin
      vi5 = 1;
      di5 = {itof(k), itof(k)};
      @(posedge clk); #1;
      vi5 = 0;
      if (k == 6 || k == 8 || k == 16 || k == 18) begin
        chk("vo5", vo5, 1);
        chk("dout5", do5, {e5[w], e5[w]});
        w++;
      end else chk("vo5_idle", vo5, 0);
      chk("done5", done5, k == 24);
      chk("busy5", busy5, k != 24);
    end
    @(posedge clk); #1;
    chk("vo5_after", vo5, 0);
    chk("done5_after", done5, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout4", do4, 0);
    chk("rst_vo4", vo4, 0);
    chk("rst_done4", done4, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_dout5", do5, 0);
    resetn = 1;
    last4 = '0;
    @(posedge clk); #1;
    frame4(0, 0, 16);
    frame4(0, 1, 16);
    frame4(0, 0, 6);
    chk("pre_rst_vo4", vo4, 1);
    resetn = 0;
    #1;
    chk("mid_rst_dout4", do4, 0);
    chk("mid_rst_vo4", vo4, 0);
    chk("mid_rst_busy4", busy4, 0);
    chk("mid_rst_done4", done4, 0);
    last4 = '0;
    #2 resetn = 1;
    @(posedge clk); #1;
    frame4(1, 0, 16);
    frame4(0, 0, 16);
    frame4(1, 0, 16);
    @(posedge clk); #1;
    chk("b2b_done_clear", done4, 0);
    chk("b2b_busy_clear", busy4, 0);
    frame5();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
